uart_param: RTL and testbench
=============================

Name: uart_param

Overview:
Parametrised full-duplex UART. It is the successor to the fixed 8N1 / 12 MHz / 9600-baud UART. The divisor, data width and stop-bit count are generics, and optional parity is added. It adds an RX input synchroniser, start-bit glitch rejection, centre-of-bit sampling, and framing/overrun reporting. It sits between the external serial pins and the on-chip byte-stream consumers, using valid/ready handshakes on both directions.

Parameters:
CLOCK_HZ, 12000000, system clock frequency in Hz
BAUD_HZ, 9600, line rate; DIV = CLOCK_HZ/BAUD_HZ (integer division); 4 <= DIV < 2^20 is required, else compile-time error
DATA_BITS, 8, data bits per frame, legal range 5..8, sent LSB first
STOP_BITS, 1, TX stop bits, 1 or 2; RX always checks only the first stop bit
SYNC_STAGES, 2, depth of the serial_rx synchroniser, >= 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
serial_rx  in  1  asynchronous RX line, idles high
rx_ready  in  1  consumer accepts rx_byte
rx_valid  out  1  rx_byte/rx_frame_err/rx_parity_err hold a received frame
rx_byte  out  DATA_BITS  received data
rx_frame_err  out  1  sampled stop bit was 0; qualified by rx_valid
rx_parity_err  out  1  parity mismatch; qualified by rx_valid; constant 0 without UART_PARITY_EN
rx_overrun  out  1  one-cycle pulse: a completed frame was dropped
serial_tx  out  1  TX line
tx_byte  in  DATA_BITS  data to send
tx_valid  in  1  tx_byte is valid
tx_ready  out  1  transmitter idle, tx_byte will be accepted

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Both FSMs go to IDLE; all timers and counters clear.
  - serial_tx=1, tx_ready=1.
  - rx_valid=0, rx_byte=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0.
  - Synchroniser flops reset to 1.
- Timers: each is a 20-bit down-counter. One bit period is exactly DIV cycles.
- TX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
  - Transfer occurs on a cycle with tx_valid && tx_ready. tx_byte is latched into the shift register; the next cycle enters START.
  - serial_tx values: 1 in IDLE, 0 in START, shift[0] in DATA, parity bit in PARITY, 1 in STOP. serial_tx is registered and glitch-free.
  - START, each DATA bit and PARITY each last DIV cycles. STOP lasts STOP_BITS*DIV cycles.
  - tx_ready=1 only in IDLE. Accept-cycle to next-accept-possible = (1+DATA_BITS+P+STOP_BITS)*DIV + 1 cycles, where P=1 with parity else 0.
  - tx_valid held high continuously gives back-to-back frames with exactly that spacing.
  - tx_byte changes while not ready are ignored.
- RX datapath: serial_rx passes through SYNC_STAGES flops; the FSM sees only rxs, the synchroniser output.
- RX FSM, states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
  - IDLE: when rxs==0, enter START with timer = DIV/2 - 1.
  - START: on expiry, re-sample rxs.
    - rxs==1: glitch; return to IDLE with no output.
    - rxs==0: enter DATA with timer = DIV-1.
  - DATA: sample at each expiry (bit centre); shift in LSB first; after DATA_BITS samples go to PARITY or STOP. Timer reloads DIV-1 at every sample.
  - STOP: sample at centre. frame_err = !rxs. Commit the frame and return to IDLE in the same cycle. RX does not wait out the stop bit, so back-to-back frames are caught.
- Commit and handshake:
  - If rx_valid==0, or rx_valid && rx_ready in the commit cycle: load rx_byte and error flags; rx_valid=1 next cycle.
  - If rx_valid==1 && !rx_ready: the new frame is dropped, the held data is unchanged, and rx_overrun pulses for 1 cycle.
  - rx_valid clears the cycle after rx_valid && rx_ready, unless a commit happens in that same cycle (then it stays 1 with the new data).
- A line stuck low: after a frame with frame_err, IDLE sees rxs==0 and starts a new frame. This is accepted behaviour.

Optional Feature:
UART_PARITY_EN: adds the PARITY state to both FSMs and the parameter PARITY_ODD (default 0 = even).
- TX sends XOR(data)^PARITY_ODD after the data bits.
- RX samples the parity bit at its centre; rx_parity_err = received bit != XOR(data)^PARITY_ODD.
- Without the macro: no parity bit is sent or expected, frame length uses P=0, and rx_parity_err is tied to 0.

Test Plan:
- Bench configuration for all scenarios: CLOCK_HZ=10, BAUD_HZ=1 (DIV=10), DATA_BITS=8, STOP_BITS=1, no parity.
- TX: send 0xA5 -> serial_tx = 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles; tx_ready returns 101 cycles after the accept cycle.
- RX loopback (serial_tx->serial_rx): send 0x3C then 0xC3 back-to-back with rx_ready=1 -> two rx_valid pulses carrying 0x3C and 0xC3; frame_err=0; no overrun.
- Glitch: drive serial_rx low for 3 cycles -> no rx_valid; FSM back in IDLE; a following valid frame 0x55 is received correctly.
- Framing: frame 0x0F with stop bit driven 0 -> rx_valid=1, rx_byte=0x0F, rx_frame_err=1.
- Overrun: hold rx_ready=0 and receive 0x11 then 0x22 -> rx_byte stays 0x11; one rx_overrun pulse; after rx_ready, rx_valid drops next cycle.
- Reset mid-frame: assert reset during TX data bit 3 and during an RX frame -> serial_tx=1 and tx_ready=1 immediately, rx_valid=0; the next 0x81 transfers cleanly (with UART_PARITY_EN, PARITY_ODD=0: parity bit=0, rx_parity_err=0).

Source files
------------

// File: rtl/uart_param_if.sv
// uart_param_if: serial pins plus the RX/TX valid/ready byte streams of uart_param.
// The slave modport is the UART side; the master modport is the pin driver / byte consumer side.
interface uart_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_rx;
  logic                 serial_tx;
  logic                 rx_ready;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_valid;
  logic                 tx_ready;

  modport slave (
    input  serial_rx, rx_ready, tx_byte, tx_valid,
    output serial_tx, rx_valid, rx_byte, rx_frame_err, rx_parity_err, rx_overrun, tx_ready
  );

  modport master (
    output serial_rx, rx_ready, tx_byte, tx_valid,
    input  serial_tx, rx_valid, rx_byte, rx_frame_err, rx_parity_err, rx_overrun, tx_ready
  );
endinterface

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with valid/ready byte streams.
// Bit period is DIV = CLOCK_HZ/BAUD_HZ cycles, timed by 20-bit down-counters.
// RX: synchroniser, start-bit glitch rejection, centre sampling, framing and overrun reporting.
// Optional feature macro UART_PARITY_EN: adds a parity bit (PARITY_ODD selects odd parity).
//
// state  | meaning
// IDLE   | line idle, waiting for tx_valid (TX) or a falling edge on rxs (RX)
// START  | start bit (TX drives 0; RX waits half a bit and re-checks for a glitch)
// DATA   | data bits, LSB first
// PARITY | parity bit (UART_PARITY_EN only)
// STOP   | stop bit(s); RX commits the frame at the centre of the first stop bit
module uart_param #(
  parameter int CLOCK_HZ    = 12000000,
  parameter int BAUD_HZ     = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic       clock,
  input logic       reset,
  uart_param_if.slave bus
);
  localparam int          DIV       = CLOCK_HZ / BAUD_HZ;
  localparam logic [19:0] DIV_M1    = 20'(DIV - 1);
  localparam logic [19:0] HALF_M1   = 20'(DIV / 2 - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  if (DIV < 4 || DIV >= 1048576) begin : g_bad_div
    $error("uart_param: CLOCK_HZ/BAUD_HZ must be in 4..2^20-1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_param: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_param: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_param: SYNC_STAGES must be at least 2");
  end

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               tx_state;
  logic [19:0]          tx_timer;
  logic [2:0]           tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 serial_tx_r;
  logic                 tx_ready_r;

  state_t               rx_state;
  logic [19:0]          rx_timer;
  logic [2:0]           rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic [SYNC_STAGES-1:0] sync;
  logic                 rxs;
  logic                 rx_valid_r;
  logic [DATA_BITS-1:0] rx_byte_r;
  logic                 rx_frame_err_r;
  logic                 rx_overrun_r;

`ifdef UART_PARITY_EN
  logic tx_par;
  logic rx_par_bad;
  logic rx_parity_err_r;
  assign bus.rx_parity_err = rx_parity_err_r;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  assign rxs              = sync[SYNC_STAGES-1];
  assign bus.serial_tx    = serial_tx_r;
  assign bus.tx_ready     = tx_ready_r;
  assign bus.rx_valid     = rx_valid_r;
  assign bus.rx_byte      = rx_byte_r;
  assign bus.rx_frame_err = rx_frame_err_r;
  assign bus.rx_overrun   = rx_overrun_r;

  // TX FSM: accept a byte in IDLE, then shift out start/data/[parity]/stop with a registered line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state    <= IDLE;
      tx_timer    <= '0;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      serial_tx_r <= 1'b1;
      tx_ready_r  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      case (tx_state)
        IDLE: begin
          if (bus.tx_valid) begin
            tx_shift    <= bus.tx_byte;
            tx_timer    <= DIV_M1;
            serial_tx_r <= 1'b0;
            tx_ready_r  <= 1'b0;
            tx_state    <= START;
`ifdef UART_PARITY_EN
            tx_par      <= (^bus.tx_byte) ^ PARITY_ODD;
`endif
          end
        end
        START: begin
          if (tx_timer == 20'd0) begin
            tx_timer    <= DIV_M1;
            tx_cnt      <= 3'd0;
            serial_tx_r <= tx_shift[0];
            tx_state    <= DATA;
          end else begin
            tx_timer <= tx_timer - 20'd1;
          end
        end
        DATA: begin
          if (tx_timer == 20'd0) begin
            tx_timer <= DIV_M1;
            if (tx_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
              serial_tx_r <= tx_par;
              tx_state    <= PARITY;
`else
              serial_tx_r <= 1'b1;
              tx_cnt      <= 3'd0;
              tx_state    <= STOP;
`endif
            end else begin
              tx_cnt      <= tx_cnt + 3'd1;
              tx_shift    <= tx_shift >> 1;
              serial_tx_r <= tx_shift[1];
            end
          end else begin
            tx_timer <= tx_timer - 20'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tx_timer == 20'd0) begin
            tx_timer    <= DIV_M1;
            tx_cnt      <= 3'd0;
            serial_tx_r <= 1'b1;
            tx_state    <= STOP;
          end else begin
            tx_timer <= tx_timer - 20'd1;
          end
        end
`endif
        STOP: begin
          // Each stop bit reloads the timer so 2*DIV never has to fit in 20 bits.
          if (tx_timer == 20'd0) begin
            if (tx_cnt == LAST_STOP) begin
              tx_ready_r <= 1'b1;
              tx_state   <= IDLE;
            end else begin
              tx_cnt   <= tx_cnt + 3'd1;
              tx_timer <= DIV_M1;
            end
          end else begin
            tx_timer <= tx_timer - 20'd1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX synchroniser: idles high so reset does not look like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], bus.serial_rx};
  end

  // RX FSM plus output holding register: centre sampling, commit at stop-bit centre, overrun on a full holding register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state       <= IDLE;
      rx_timer       <= '0;
      rx_cnt         <= '0;
      rx_shift       <= '0;
      rx_valid_r     <= 1'b0;
      rx_byte_r      <= '0;
      rx_frame_err_r <= 1'b0;
      rx_overrun_r   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad      <= 1'b0;
      rx_parity_err_r <= 1'b0;
`endif
    end else begin
      rx_overrun_r <= 1'b0;
      if (rx_valid_r && bus.rx_ready) rx_valid_r <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (!rxs) begin
            rx_timer <= HALF_M1;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_timer == 20'd0) begin
            if (rxs) begin
              rx_state <= IDLE;
            end else begin
              rx_timer <= DIV_M1;
              rx_cnt   <= 3'd0;
              rx_state <= DATA;
            end
          end else begin
            rx_timer <= rx_timer - 20'd1;
          end
        end
        DATA: begin
          if (rx_timer == 20'd0) begin
            rx_timer <= DIV_M1;
            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
            if (rx_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end else begin
              rx_cnt <= rx_cnt + 3'd1;
            end
          end else begin
            rx_timer <= rx_timer - 20'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (rx_timer == 20'd0) begin
            rx_par_bad <= rxs ^ (^rx_shift) ^ PARITY_ODD;
            rx_timer   <= DIV_M1;
            rx_state   <= STOP;
          end else begin
            rx_timer <= rx_timer - 20'd1;
          end
        end
`endif
        STOP: begin
          if (rx_timer == 20'd0) begin
            rx_state <= IDLE;
            if (!rx_valid_r || bus.rx_ready) begin
              rx_byte_r      <= rx_shift;
              rx_frame_err_r <= !rxs;
              rx_valid_r     <= 1'b1;
`ifdef UART_PARITY_EN
              rx_parity_err_r <= rx_par_bad;
`endif
            end else begin
              rx_overrun_r <= 1'b1;
            end
          end else begin
            rx_timer <= rx_timer - 20'd1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed checks of uart_param at DIV=10, 8N1.
module tb_uart_param;
  localparam int DIV = 10;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic loop   = 1'b0;
  logic rx_drv = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ov_cnt   = 0;
  logic [9:0] rx_q[$];

  uart_param_if #(.DATA_BITS(8)) bus ();

  uart_param #(
    .CLOCK_HZ(10), .BAUD_HZ(1), .DATA_BITS(8), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always_comb bus.serial_rx = loop ? bus.serial_tx : rx_drv;

  // Record every accepted RX frame as {parity_err, frame_err, byte} and count overrun pulses.
  always @(negedge clock) begin
    if (bus.rx_valid && bus.rx_ready)
      rx_q.push_back({bus.rx_parity_err, bus.rx_frame_err, bus.rx_byte});
    if (bus.rx_overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.tx_ready && n < 300);
    if (!bus.tx_ready) check("tx_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx_drv = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.tx_byte  = b;
    bus.tx_valid = 1'b1;
    @(posedge clock);
    #1 bus.tx_valid = 1'b0;
  endtask

  initial begin
    int         n;
    int         base;
    int         ov0;
    logic [9:0] frame;
    logic [9:0] seen;
    logic       busy_hi;

    bus.tx_byte  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_serial_tx", bus.serial_tx, 1);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_byte", bus.rx_byte, 0);
    check("rst_frame_err", bus.rx_frame_err, 0);
    check("rst_overrun", bus.rx_overrun, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // TX 0xA5: start, LSB-first data, stop, each 10 cycles; ready back at cycle 101
    frame   = {1'b1, 8'hA5, 1'b0};
    busy_hi = 1'b0;
    send_byte(8'hA5);
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        seen[k] = bus.serial_tx;
        busy_hi = busy_hi | bus.tx_ready;
      end
      check($sformatf("tx_bit%0d", p), seen, {10{frame[p]}});
    end
    check("tx_ready_busy", busy_hi, 0);
    @(negedge clock);
    check("tx_ready_101", bus.tx_ready, 1);

    // Loopback 0x3C then 0xC3 back-to-back, tx_valid held
    repeat (3) @(negedge clock);
    base = rx_q.size();
    ov0  = ov_cnt;
    loop = 1'b1;
    bus.rx_ready = 1'b1;
    bus.tx_byte  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(posedge clock);
    #1 bus.tx_byte = 8'hC3;
    wait_ready(n);
    check("b2b_spacing", n, 101);
    @(posedge clock);
    #1 bus.tx_valid = 1'b0;
    repeat (130) @(negedge clock);
    check("lb_count", rx_q.size() - base, 2);
    check("lb_byte0", rx_q[base], {2'b00, 8'h3C});
    check("lb_byte1", rx_q[base+1], {2'b00, 8'hC3});
    check("lb_overrun", ov_cnt - ov0, 0);
    loop = 1'b0;

    // Glitch of 3 cycles, then a real 0x55
    repeat (5) @(negedge clock);
    base = rx_q.size();
    rx_drv = 1'b0;
    repeat (3) @(negedge clock);
    rx_drv = 1'b1;
    repeat (20) @(negedge clock);
    check("glitch_no_frame", rx_q.size() - base, 0);
    check("glitch_rx_valid", bus.rx_valid, 0);
    drive_frame(8'h55, 1'b1);
    repeat (5) @(negedge clock);
    check("glitch_next_count", rx_q.size() - base, 1);
    check("glitch_next_frame", rx_q[base], {2'b00, 8'h55});

    // Framing error: 0x0F with stop bit 0
    base = rx_q.size();
    drive_frame(8'h0F, 1'b0);
    repeat (20) @(negedge clock);
    check("fe_count", rx_q.size() - base, 1);
    check("fe_frame", rx_q[base], {2'b01, 8'h0F});

    // Overrun: 0x11 held, 0x22 dropped
    bus.rx_ready = 1'b0;
    base = rx_q.size();
    ov0  = ov_cnt;
    drive_frame(8'h11, 1'b1);
    drive_frame(8'h22, 1'b1);
    check("ovr_valid", bus.rx_valid, 1);
    check("ovr_byte_held", bus.rx_byte, 8'h11);
    check("ovr_pulses", ov_cnt - ov0, 1);
    @(posedge clock);
    #1 bus.rx_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("ovr_valid_drop", bus.rx_valid, 0);
    check("ovr_drain_count", rx_q.size() - base, 1);
    check("ovr_drain_byte", rx_q[base], {2'b00, 8'h11});

    // Reset during TX data bit 3 and an RX frame, with an RX byte held
    bus.rx_ready = 1'b0;
    drive_frame(8'h5A, 1'b1);
    check("pre_rst_rx_valid", bus.rx_valid, 1);
    send_byte(8'hA5);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (k == 1) rx_drv = 1'b0;
    end
    check("pre_rst_tx_bit3", bus.serial_tx, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_serial_tx", bus.serial_tx, 1);
    check("mid_rst_tx_ready", bus.tx_ready, 1);
    check("mid_rst_rx_valid", bus.rx_valid, 0);
    check("mid_rst_rx_byte", bus.rx_byte, 0);
    @(negedge clock);
    rx_drv = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    base = rx_q.size();
    loop = 1'b1;
    bus.rx_ready = 1'b1;
    send_byte(8'h81);
    repeat (130) @(negedge clock);
    check("post_rst_count", rx_q.size() - base, 1);
    check("post_rst_frame", rx_q[base], {2'b00, 8'h81});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
